div_iter: RTL

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter_pkg.sv | 26 ++
 rtl/div_iter_step.sv | 22 ++
 rtl/div_iter.sv | 118 +++++++++++
 3 files changed

// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, iteration
// count, result field layout and operand magnitude helper.
package div_iter_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } divState_t;

  // Number of shift-subtract steps and the counter width that holds it
  localparam int unsigned DivIterations = 32;
  localparam int unsigned DivCntWidth   = 6;

  // result_o layout: remainder in HI, quotient in LO
  localparam int unsigned ResHiMsb = 63;
  localparam int unsigned ResHiLsb = 32;
  localparam int unsigned ResLoMsb = 31;
  localparam int unsigned ResLoLsb = 0;

  // Magnitude of an operand; 0x80000000 maps to 2^31 as an unsigned value
  function automatic logic [31:0] absVal(input logic [31:0] v, input logic isSigned);
    return (isSigned && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring division iteration: shift in the next dividend bit and
// subtract the divisor when it fits.
module div_step (
  input  logic [32:0] remIn,
  input  logic        dividendBit,
  input  logic [31:0] divisor,
  output logic [32:0] remOut,
  output logic        quotBit
);

  logic [33:0] shifted;
  logic [33:0] trial;

  // Trial subtraction; a non-negative difference means the divisor fits
  always_comb begin
    shifted = {remIn, dividendBit};
    trial   = shifted - {2'b00, divisor};
    quotBit = ~trial[33];
    remOut  = quotBit ? trial[32:0] : shifted[32:0];
  end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle signed/unsigned 32-bit divider for the E stage. Holds the
// pipeline via stall_o and presents {remainder, quotient} on result_o.
module div_iter
  import div_iter_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stall_o
);

  divState_t              state;
  divState_t              nextState;
  logic [DivCntWidth-1:0] count;
  logic [31:0]            dividendReg;
  logic [31:0]            divisorReg;
  logic [31:0]            quotReg;
  logic [32:0]            remReg;
  logic                   dividendNeg;
  logic                   divisorNeg;
  logic                   signedReg;
  logic [32:0]            stepRem;
  logic                   stepQ;
  logic                   accept;
  logic                   lastStep;
  logic [31:0]            fullQuot;
  logic [31:0]            finalQuot;
  logic [31:0]            finalRem;

  div_step uStep (
    .remIn       (remReg),
    .dividendBit (dividendReg[31]),
    .divisor     (divisorReg),
    .remOut      (stepRem),
    .quotBit     (stepQ)
  );

  // Handshake decode and sign fixup of the final step's outputs
  always_comb begin
    accept    = (state == DIV_IDLE) && start_i && !annul_i;
    lastStep  = (state == DIV_BUSY) && (count == DivCntWidth'(DivIterations - 1));
    fullQuot  = {quotReg[30:0], stepQ};
    finalQuot = (signedReg && (dividendNeg ^ divisorNeg)) ? (~fullQuot + 32'd1) : fullQuot;
    finalRem  = (signedReg && dividendNeg) ? (~stepRem[31:0] + 32'd1) : stepRem[31:0];
    ready_o   = (state == DIV_DONE);
    stall_o   = start_i && !ready_o && !annul_i;
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= DIV_IDLE;
    else         state <= nextState;
  end

  // Next-state logic; annul wins in every state
  always_comb begin
    nextState = state;
    if (annul_i) begin
      nextState = DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (accept) nextState = (opdata2_i == '0) ? DIV_DONE : DIV_BUSY;
        DIV_BUSY: if (lastStep) nextState = DIV_DONE;
        DIV_DONE: nextState = DIV_IDLE;
        default:  nextState = DIV_IDLE;
      endcase
    end
  end

  // Operand capture, iteration datapath and result register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count       <= '0;
      dividendReg <= '0;
      divisorReg  <= '0;
      quotReg     <= '0;
      remReg      <= '0;
      dividendNeg <= 1'b0;
      divisorNeg  <= 1'b0;
      signedReg   <= 1'b0;
      result_o    <= '0;
    end else if (!annul_i) begin
      case (state)
        DIV_IDLE: begin
          if (start_i) begin
            dividendReg <= absVal(opdata1_i, signed_i);
            divisorReg  <= absVal(opdata2_i, signed_i);
            dividendNeg <= signed_i & opdata1_i[31];
            divisorNeg  <= signed_i & opdata2_i[31];
            signedReg   <= signed_i;
            count       <= '0;
            quotReg     <= '0;
            remReg      <= '0;
            if (opdata2_i == '0) result_o <= '0;
          end
        end
        DIV_BUSY: begin
          dividendReg <= {dividendReg[30:0], 1'b0};
          quotReg     <= fullQuot;
          remReg      <= stepRem;
          count       <= count + 1'b1;
          if (lastStep) begin
            result_o[ResHiMsb:ResHiLsb] <= finalRem;
            result_o[ResLoMsb:ResLoLsb] <= finalQuot;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
